// File: rtl/sdram_mport.sv
// N-channel round-robin front end for the single-port sdram controller.
// Optional: define SDRAM_MPORT_PRIO_EN for channel 0 strict priority.
module sdram_mport #(
  parameter int CHANNELS = 2,
  parameter int AW       = 24,
  parameter int DW       = 16,
  parameter int RD_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           ch_avalid,
  input  logic [CHANNELS-1:0]           ch_awe,
  input  logic [CHANNELS*AW-1:0]        ch_aaddr,
  input  logic [CHANNELS*DW-1:0]        ch_adata,
  output logic [CHANNELS-1:0]           ch_aready,
  output logic [DW-1:0]                 ch_bdata,
  output logic [CHANNELS-1:0]           ch_bvalid,
  output logic                          avalid,
  output logic                          awe,
  output logic [AW-1:0]                 aaddr,
  output logic [DW-1:0]                 adata,
  input  logic                          aready,
  input  logic [DW-1:0]                 bdata,
  input  logic                          bvalid,
  output logic [$clog2(RD_DEPTH):0]     rd_pending,
  output logic                          orphan_err
);

  localparam int CW = $clog2(CHANNELS);
  localparam int PW = $clog2(RD_DEPTH);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_grant, r_rr, w_pick;
  logic                w_found;
  logic [CHANNELS-1:0] w_elig;
  logic [CW-1:0]       r_tag [RD_DEPTH];
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [PW:0]         r_cnt;
  logic                r_orphan;
  logic                w_full, w_empty, w_acc, w_push, w_pop;

  assign w_full  = (r_cnt == (PW+1)'(RD_DEPTH));
  assign w_empty = (r_cnt == '0);
  // Reads wait while the tag FIFO is full; writes never do.
  assign w_elig  = ch_avalid & (ch_awe | {CHANNELS{~w_full}});
  assign w_acc   = (r_state == S_BUSY) && aready;
  assign w_push  = w_acc && !awe;
  assign w_pop   = bvalid && !w_empty;

  // First eligible channel after the rr pointer. In priority mode channel 0
  // wins outright; otherwise it is never eligible when the scan runs.
  always_comb begin
    int t;
    t       = 0;
    w_found = 1'b0;
    w_pick  = r_rr;
`ifdef SDRAM_MPORT_PRIO_EN
    if (w_elig[0]) begin
      w_found = 1'b1;
      w_pick  = '0;
    end
`endif
    for (int k = 1; k <= CHANNELS; k++) begin
      t = (int'(r_rr) + k) % CHANNELS;
      if (!w_found && w_elig[CW'(t)]) begin
        w_found = 1'b1;
        w_pick  = CW'(t);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    avalid      = 1'b0;
    awe         = 1'b0;
    aaddr       = '0;
    adata       = '0;
    ch_aready   = '0;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_BUSY;
      S_BUSY: begin
        avalid = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
          if (r_grant == CW'(i)) begin
            awe          = ch_awe[i];
            aaddr        = ch_aaddr[i*AW +: AW];
            adata        = ch_adata[i*DW +: DW];
            ch_aready[i] = aready;
          end
        end
        if (aready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr     <= CW'(CHANNELS-1);
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_orphan <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_found) r_grant <= w_pick;
`ifdef SDRAM_MPORT_PRIO_EN
      if (w_acc && r_grant != '0) r_rr <= r_grant;
`else
      if (w_acc) r_rr <= r_grant;
`endif
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
      if (bvalid && w_empty) r_orphan <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) r_tag[r_wptr] <= r_grant;
  end

  always_comb begin
    ch_bvalid = '0;
    if (w_pop) ch_bvalid[r_tag[r_rptr]] = 1'b1;
  end

  assign ch_bdata   = bdata;
  assign rd_pending = r_cnt;
  assign orphan_err = r_orphan;

endmodule

// File: tb/tb_sdram_mport.sv
// Randomized bench for sdram_mport with a queue-based channel/controller model.
`timescale 1ns/1ps
module tb_sdram_mport;
  localparam int CH = 2, AW = 24, DW = 16, RD = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [CH-1:0]    ch_avalid, ch_awe, ch_aready, ch_bvalid;
  logic [CH*AW-1:0] ch_aaddr;
  logic [CH*DW-1:0] ch_adata;
  logic [DW-1:0]    ch_bdata, adata, bdata;
  logic             avalid, awe, aready, bvalid, orphan_err;
  logic [AW-1:0]    aaddr;
  logic [$clog2(RD):0] rd_pending;

  sdram_mport #(.CHANNELS(CH), .AW(AW), .DW(DW), .RD_DEPTH(RD)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ch_avalid(ch_avalid), .ch_awe(ch_awe), .ch_aaddr(ch_aaddr), .ch_adata(ch_adata),
    .ch_aready(ch_aready), .ch_bdata(ch_bdata), .ch_bvalid(ch_bvalid),
    .avalid(avalid), .awe(awe), .aaddr(aaddr), .adata(adata), .aready(aready),
    .bdata(bdata), .bvalid(bvalid), .rd_pending(rd_pending), .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;

  req_t          q0[$], q1[$];
  logic [DW-1:0] mem [int];
  logic [DW-1:0] resp[$];
  logic [DW-1:0] rdat[$];
  int            owner[$];
  int            acc_log[$], bv_log[$];
  int            pend = 0, peak = 0, cyc = 0, last_acc = -10;
  int            ardy_pct = 100, bv_pct = 100;
  bit            hold_b = 0, inject = 0, gen_en = 0;
  logic          orphan_exp = 1'b0;
  int            n_tests = 0, n_fail = 0;
  int            exp2[8];
  int            exp3[3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.we = we; r.addr = a; r.data = d;
    return r;
  endfunction

  // Unwritten locations read back as an address-derived pattern.
  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return DW'(a * 7 + 3);
  endfunction

  task automatic drive();
    req_t r;
    ch_avalid = '0; ch_awe = '0; ch_aaddr = '0; ch_adata = '0;
    if (q0.size() > 0) begin
      r = q0[0];
      ch_avalid[0] = 1'b1; ch_awe[0] = r.we;
      ch_aaddr[0 +: AW] = r.addr; ch_adata[0 +: DW] = r.data;
    end
    if (q1.size() > 0) begin
      r = q1[0];
      ch_avalid[1] = 1'b1; ch_awe[1] = r.we;
      ch_aaddr[AW +: AW] = r.addr; ch_adata[DW +: DW] = r.data;
    end
    aready = (int'($urandom_range(99)) < ardy_pct);
    bvalid = inject || (!hold_b && resp.size() > 0 && int'($urandom_range(99)) < bv_pct);
    bdata  = (resp.size() > 0 && !inject) ? resp[0] : DW'($urandom);
  endtask

  task automatic step();
    logic acc, bv;
    int g;
    req_t r;
    logic [CH-1:0] exp_bv;
    logic [DW-1:0] d;
    @(negedge clk);
    cyc++;
    acc = avalid && aready;
    bv  = bvalid;
    if (int'(rd_pending) > peak) peak = int'(rd_pending);
    chk("rd_pending", rd_pending, pend);
    chk("orphan_err", orphan_err, orphan_exp);
    if (!avalid) chk("idle_zero", {awe, aaddr, adata}, 0);
    exp_bv = '0;
    if (bv && pend > 0) exp_bv[owner[0]] = 1'b1;
    chk("ch_bvalid", ch_bvalid, exp_bv);
    if (bv && pend > 0) chk("ch_bdata", ch_bdata, rdat[0]);
    if (bv) begin
      if (pend > 0) begin
        bv_log.push_back(owner[0]);
        void'(owner.pop_front()); void'(rdat.pop_front());
        pend--;
      end else orphan_exp = 1'b1;
      if (!inject && resp.size() > 0) void'(resp.pop_front());
      inject = 0;
    end
    if (acc) begin
      g = -1;
      for (int i = CH-1; i >= 0; i--) if (ch_aready[i]) g = i;
      chk("aready_1hot", $countones(ch_aready), 1);
      if (g == 0 && q0.size() > 0) r = q0[0];
      else if (g == 1 && q1.size() > 0) r = q1[0];
      else g = -1;
      if (g < 0) chk("aready_owner", 0, 1);
      else begin
        chk("cmd_we", awe, r.we);
        chk("cmd_addr", aaddr, r.addr);
        if (r.we) chk("cmd_data", adata, r.data);
        chk("bubble", (cyc - last_acc) >= 2, 1);
        last_acc = cyc;
        acc_log.push_back(int'(r.addr));
        if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        if (r.we) mem[int'(r.addr)] = r.data;
        else begin
          d = mem_rd(r.addr);
          resp.push_back(d); rdat.push_back(d); owner.push_back(g);
          pend++;
        end
      end
    end else chk("aready_quiet", ch_aready, 0);
    if (gen_en) begin
      if (q0.size() < 2 && $urandom_range(99) < 40)
        q0.push_back(mk(1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom)));
      if (q1.size() < 2 && $urandom_range(99) < 40)
        q1.push_back(mk(1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom)));
    end
    @(posedge clk); #1;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || resp.size() > 0 || pend > 0) && n < max) begin
      step(); n++;
    end
    if (q0.size() > 0 || q1.size() > 0 || resp.size() > 0 || pend > 0) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
`ifdef SDRAM_MPORT_PRIO_EN
    exp2 = '{1, 2, 3, 4, 512, 513, 514, 515};
    exp3 = '{0, 0, 1};
`else
    exp2 = '{1, 512, 2, 513, 3, 514, 4, 515};
    exp3 = '{0, 1, 0};
`endif
    ch_avalid = '0; ch_awe = '0; ch_aaddr = '0; ch_adata = '0;
    aready = 1'b0; bvalid = 1'b0; bdata = '0;
    #12;
    chk("rst_avalid", avalid, 0);
    chk("rst_awe", awe, 0);
    chk("rst_aaddr", aaddr, 0);
    chk("rst_adata", adata, 0);
    chk("rst_ch_aready", ch_aready, 0);
    chk("rst_ch_bvalid", ch_bvalid, 0);
    chk("rst_rd_pending", rd_pending, 0);
    chk("rst_orphan", orphan_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    drive();

    // Two channels writing back to back.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b1, AW'(1 + i), DW'(16'h1000 + i)));
      q1.push_back(mk(1'b1, AW'(512 + i), DW'(16'h2000 + i)));
    end
    acc_log.delete();
    drain(100);
    chk("wr_order_n", acc_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < acc_log.size()) chk("wr_order", acc_log[i], exp2[i]);

    // Three reads returned in order.
    hold_b = 1; bv_log.delete(); peak = 0;
    q0.push_back(mk(1'b0, AW'(2), '0));
    q0.push_back(mk(1'b0, AW'(4), '0));
    q1.push_back(mk(1'b0, AW'(3), '0));
    run(20);
    chk("rd_peak", peak, 3);
    hold_b = 0;
    drain(100);
    chk("rd_route_n", bv_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < bv_log.size()) chk("rd_route", bv_log[i], exp3[i]);

    // Tag FIFO full: fifth read held, write still granted.
    hold_b = 1;
    for (int i = 0; i < 5; i++) q0.push_back(mk(1'b0, AW'(10 + i), '0));
    run(30);
    chk("full_pend", rd_pending, RD);
    chk("full_held", q0.size(), 1);
    q1.push_back(mk(1'b1, AW'(8197), DW'(16'hbeef)));
    run(10);
    chk("full_wr_done", q1.size(), 0);
    chk("full_wr_addr", acc_log[$], 8197);
    chk("full_still_held", q0.size(), 1);
    hold_b = 0;
    drain(100);

    // Random traffic with random back-pressure on both sides.
    gen_en = 1;
    for (int r = 0; r < 6; r++) begin
      ardy_pct = int'($urandom_range(100, 30));
      bv_pct   = int'($urandom_range(90, 20));
      run(100);
    end
    gen_en = 0; ardy_pct = 100; bv_pct = 100;
    drain(500);

    // Return with nothing outstanding.
    inject = 1;
    drive();
    run(6);
    chk("orphan_sticky", orphan_err, 1);

    // Reset while a grant is waiting on the controller.
    hold_b = 1;
    q0.push_back(mk(1'b0, AW'(20), '0));
    q0.push_back(mk(1'b0, AW'(21), '0));
    run(10);
    chk("pre_rst_pend", rd_pending, 2);
    ardy_pct = 0;
    q1.push_back(mk(1'b1, AW'(30), DW'(16'h0055)));
    run(3);
    chk("pre_rst_busy", avalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_avalid", avalid, 0);
    chk("mid_rst_aready", ch_aready, 0);
    chk("mid_rst_pending", rd_pending, 0);
    chk("mid_rst_orphan", orphan_err, 0);
    q0.delete(); q1.delete(); owner.delete(); rdat.delete();
    pend = 0; orphan_exp = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    hold_b = 0; ardy_pct = 100;
    drive();
    drain(100);
    chk("orphan_after_rst", orphan_err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
